// File: rtl/regfile_pkg.sv
// Shared constants and types for the multi-port register file.
package regfile_pkg;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_DEPTH = 16;
  localparam int unsigned DEF_NREAD = 2;
  localparam int unsigned MAX_NREAD = 4;

  // Sequenced-clear controller states
  typedef enum logic {
    CLR_IDLE = 1'b0,
    CLR_RUN  = 1'b1
  } clr_state_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-result scoreboard: one bit per register, set by reservations,
// cleared by writeback and by the sequenced clear. A set wins over a
// same-cycle clear of the same entry.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned NREAD  = DEF_NREAD,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_set,
  input  logic [ADDR_W-1:0]       i_set_addr,
  input  logic                    i_clr,
  input  logic [ADDR_W-1:0]       i_clr_addr,
  input  logic                    i_wipe,
  input  logic [ADDR_W-1:0]       i_wipe_addr,
  input  logic [NREAD*ADDR_W-1:0] i_rd_addr,
  output logic [NREAD-1:0]        o_pending_c
);

  logic [DEPTH-1:0] r_pend;

  // Pending bits; later assignments take priority, so set beats clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend <= '0;
    end else begin
      if (i_wipe) r_pend[i_wipe_addr] <= 1'b0;
      if (i_clr)  r_pend[i_clr_addr]  <= 1'b0;
      if (i_set)  r_pend[i_set_addr]  <= 1'b1;
    end
  end

  // Per-port lookup of the registered pending bit (no bypass)
  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    assign o_pending_c[k] = r_pend[i_rd_addr[k*ADDR_W +: ADDR_W]];
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with write-to-read bypass, pending scoreboard
// and a one-entry-per-cycle sequenced clear.
// Optional feature: REGFILE_ZERO_REG_EN makes register 0 a hard-wired zero.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int unsigned WIDTH  = DEF_WIDTH,
  parameter  int unsigned DEPTH  = DEF_DEPTH,
  parameter  int unsigned NREAD  = DEF_NREAD,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    write,
  input  logic [ADDR_W-1:0]       address_w,
  input  logic [WIDTH-1:0]        data_in,
  input  logic [NREAD*ADDR_W-1:0] address_r,
  output logic [NREAD*WIDTH-1:0]  data_out,
  output logic [NREAD-1:0]        pending,
  input  logic                    reserve,
  input  logic [ADDR_W-1:0]       address_res,
  input  logic                    clear,
  output logic                    clearing
);

  clr_state_t        r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic [WIDTH-1:0]  r_mem [DEPTH];

  logic w_clearing;
  logic w_wr_en;
  logic w_res_en;

  assign w_clearing = (r_state == CLR_RUN);
  assign clearing   = w_clearing;

`ifdef REGFILE_ZERO_REG_EN
  // Register 0 is never written or reserved, so it stays zero and not pending
  assign w_wr_en  = write   & ~w_clearing & (address_w   != '0);
  assign w_res_en = reserve & ~w_clearing & (address_res != '0);
`else
  assign w_wr_en  = write   & ~w_clearing;
  assign w_res_en = reserve & ~w_clearing;
`endif

  // Clear sequencer: walks r_cnt over every entry once, then returns to idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= CLR_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        CLR_IDLE: begin
          if (clear) begin
            r_state <= CLR_RUN;
            r_cnt   <= '0;
          end
        end
        CLR_RUN: begin
          r_cnt <= r_cnt + ADDR_W'(1);
          if (r_cnt == ADDR_W'(DEPTH - 1)) r_state <= CLR_IDLE;
        end
        default: begin
          r_state <= CLR_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Data array: clear sequence has priority, writes are dropped meanwhile
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_clearing) begin
      r_mem[r_cnt] <= '0;
    end else if (w_wr_en) begin
      r_mem[address_w] <= data_in;
    end
  end

  // Combinational read ports with same-cycle write bypass
  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [ADDR_W-1:0] w_raddr;
    logic              w_byp;
    assign w_raddr = address_r[k*ADDR_W +: ADDR_W];
    assign w_byp   = w_wr_en && (address_w == w_raddr);
    assign data_out[k*WIDTH +: WIDTH] = w_byp ? data_in : r_mem[w_raddr];
  end

  regfile_scoreboard #(
    .DEPTH  (DEPTH),
    .NREAD  (NREAD),
    .ADDR_W (ADDR_W)
  ) u_sb (
    .clk         (clk),
    .rst         (rst),
    .i_set       (w_res_en),
    .i_set_addr  (address_res),
    .i_clr       (w_wr_en),
    .i_clr_addr  (address_w),
    .i_wipe      (w_clearing),
    .i_wipe_addr (r_cnt),
    .i_rd_addr   (address_r),
    .o_pending_c (pending)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp (default parameters: 32x16, two read ports).
module tb_regfile_mp;

  logic        clk;
  logic        rst;
  logic        write;
  logic [3:0]  address_w;
  logic [31:0] data_in;
  logic [7:0]  address_r;
  logic [63:0] data_out;
  logic [1:0]  pending;
  logic        reserve;
  logic [3:0]  address_res;
  logic        clear;
  logic        clearing;

  int n_total = 0;
  int n_bad   = 0;

  regfile_mp dut (
    .clk         (clk),
    .rst         (rst),
    .write       (write),
    .address_w   (address_w),
    .data_in     (data_in),
    .address_r   (address_r),
    .data_out    (data_out),
    .pending     (pending),
    .reserve     (reserve),
    .address_res (address_res),
    .clear       (clear),
    .clearing    (clearing)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [3:0] a0, input logic [3:0] a1);
    address_r = {a1, a0};
    #1;
  endtask

  int          n_clr;
  logic [31:0] exp0;
  logic        expp;

  initial begin
    rst = 1'b1; write = 1'b0; address_w = '0; data_in = '0; address_r = '0;
    reserve = 1'b0; address_res = '0; clear = 1'b0;
    repeat (2) tick();
    chk("rst_data", 64'(data_out), 64'h0);
    chk("rst_pend", 64'(pending), 64'h0);
    chk("rst_clearing", 64'(clearing), 64'h0);
    rst = 1'b0;
    tick();

    // write with bypass, then from storage
    write = 1'b1; address_w = 4'd4; data_in = 32'hACED_CAFE;
    rd(4'd4, 4'd1);
    chk("wr_bypass_p0", 64'(data_out[31:0]), 64'hACED_CAFE);
    chk("wr_other_p1", 64'(data_out[63:32]), 64'h0);
    tick();
    write = 1'b0;
    #1;
    chk("wr_stored_p0", 64'(data_out[31:0]), 64'hACED_CAFE);
    chk("wr_stored_p1", 64'(data_out[63:32]), 64'h0);

    // reserve, then writeback clears pending
    reserve = 1'b1; address_res = 4'd3;
    rd(4'd3, 4'd4);
    chk("res_not_yet", 64'(pending), 64'h0);
    tick();
    reserve = 1'b0;
    tick(); tick();
    chk("res_pending", 64'(pending), 64'h1);
    write = 1'b1; address_w = 4'd3; data_in = 32'hDEAD_BEEF;
    #1;
    chk("wb_pend_nobyp", 64'(pending), 64'h1);
    chk("wb_data_byp", 64'(data_out[31:0]), 64'hDEAD_BEEF);
    tick();
    write = 1'b0;
    #1;
    chk("wb_pend_drop", 64'(pending), 64'h0);
    chk("wb_data", 64'(data_out[31:0]), 64'hDEAD_BEEF);

    // same-cycle reserve and write: data stored, pending set
    write = 1'b1; address_w = 4'd5; data_in = 32'h55AA_0055;
    reserve = 1'b1; address_res = 4'd5;
    tick();
    write = 1'b0; reserve = 1'b0;
    rd(4'd5, 4'd3);
    chk("rw5_data", 64'(data_out[31:0]), 64'h55AA_0055);
    chk("rw5_pend", 64'(pending), 64'h1);

    // register 0 behaviour
`ifdef REGFILE_ZERO_REG_EN
    exp0 = 32'h0; expp = 1'b0;
`else
    exp0 = 32'h1234; expp = 1'b1;
`endif
    write = 1'b1; address_w = 4'd0; data_in = 32'h1234;
    reserve = 1'b1; address_res = 4'd0;
    rd(4'd1, 4'd0);
    chk("r0_bypass", 64'(data_out[63:32]), 64'(exp0));
    tick();
    write = 1'b0; reserve = 1'b0;
    #1;
    chk("r0_data", 64'(data_out[63:32]), 64'(exp0));
    chk("r0_pend", 64'(pending[1]), 64'(expp));

    // preload all entries, then mark one pending
    for (int i = 0; i < 16; i++) begin
      write = 1'b1; address_w = 4'(i); data_in = 32'h1000 + 32'(i);
      tick();
    end
    write = 1'b0;
    reserve = 1'b1; address_res = 4'd6;
    tick();
    reserve = 1'b0;
    rd(4'd6, 4'd9);
`ifdef REGFILE_ZERO_REG_EN
    chk("pre_data", 64'(data_out), {32'h1009, 32'h1006});
`else
    chk("pre_data", 64'(data_out), {32'h1009, 32'h1006});
`endif
    chk("pre_pend6", 64'(pending), 64'h1);

    // sequenced clear
    clear = 1'b1;
    tick();
    clear = 1'b0;
    n_clr = 0;
    for (int c = 0; c < 40 && clearing; c++) begin
      n_clr++;
      if (c == 2) begin
        write = 1'b1; address_w = 4'd7; data_in = 32'h7777_7777;
        rd(4'd7, 4'd15);
        chk("clr_nobyp_p0", 64'(data_out[31:0]), 64'h1007);
        chk("clr_uncleared_p1", 64'(data_out[63:32]), 64'h100F);
        write = 1'b0;
      end
      if (c == 5) clear = 1'b1;
      if (c == 6) clear = 1'b0;
      if (c == 10) begin
        write = 1'b1; address_w = 4'd7; data_in = 32'h7777_7777;
        reserve = 1'b1; address_res = 4'd9;
      end
      if (c == 11) begin
        write = 1'b0; reserve = 1'b0;
      end
      tick();
    end
    write = 1'b0; reserve = 1'b0; clear = 1'b0;
    chk("clr_len", 64'(n_clr), 64'd16);
    chk("clr_done", 64'(clearing), 64'h0);
    for (int i = 0; i < 16; i += 2) begin
      rd(4'(i), 4'(i + 1));
      chk($sformatf("clr_data_%0d", i), 64'(data_out), 64'h0);
      chk($sformatf("clr_pend_%0d", i), 64'(pending), 64'h0);
    end

    // reset in the middle of a clear
    write = 1'b1; address_w = 4'd12; data_in = 32'hCCCC_CCCC;
    tick();
    write = 1'b0;
    reserve = 1'b1; address_res = 4'd13;
    tick();
    reserve = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    repeat (8) tick();
    rd(4'd12, 4'd13);
    chk("mid_clearing", 64'(clearing), 64'h1);
    chk("mid_data12", 64'(data_out[31:0]), 64'hCCCC_CCCC);
    chk("mid_pend13", 64'(pending), 64'h2);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_clearing", 64'(clearing), 64'h0);
    chk("arst_data", 64'(data_out), 64'h0);
    chk("arst_pend", 64'(pending), 64'h0);
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_clearing", 64'(clearing), 64'h0);
    chk("post_rst_data", 64'(data_out), 64'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file: the next generation of the team's two-read/one-write register block. It has configurable width, depth and read-port count, asynchronous reset and same-cycle write-to-read bypass. A per-register pending scoreboard tracks in-flight results, and a sequenced clear operation zeroes the array one entry per cycle. The block sits between decode (read addresses, reservations) and writeback (write port) in the team's processor datapath.

## Interface
- WIDTH, 32, data bits per register
- DEPTH, 16, number of registers (power of two, ≥2)
- NREAD, 2, number of read ports (1..4)
- ADDR_W, $clog2(DEPTH), address width (derived, not overridden)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- write  in  1  write enable
- address_w  in  ADDR_W  write address
- data_in  in  WIDTH  write data
- address_r  in  NREAD*ADDR_W  read addresses, port k at bits [k*ADDR_W +: ADDR_W]
- data_out  out  NREAD*WIDTH  read data, port k at bits [k*WIDTH +: WIDTH]
- pending  out  NREAD  pending bit of the register addressed by each read port
- reserve  in  1  mark register address_res pending
- address_res  in  ADDR_W  reservation address
- clear  in  1  start a sequenced clear (pulse)
- clearing  out  1  high while a clear is in progress

## Operation
- Storage is DEPTH×WIDTH flops plus DEPTH pending bits.
- **Reads:** combinational. If write=1, clearing=0 and address_w equals the read address, data_out returns data_in (bypass). Otherwise it returns the stored value.
- **Pending output:** pending[k] reflects the registered pending bit of the addressed register. It is not bypassed.
- **Write:** on a clock edge with write=1 and clearing=0, the array stores data_in at address_w and clears pending[address_w].
- **Reserve:** on a clock edge with reserve=1 and clearing=0, pending[address_res] is set. If a reserve and a write hit the same address in the same cycle, pending ends at 1.
- **Clear FSM states:**
  - IDLE: clear=1 moves to CLEAR with counter=0.
  - CLEAR: each cycle writes 0 to array[counter], clears pending[counter] and increments counter. After entry DEPTH−1 is cleared, the FSM returns to IDLE.
- **During CLEAR:**
  - write and reserve are ignored (dropped, not queued).
  - clear is ignored.
  - Reads return stored values, including entries not yet cleared.
- **Reset:** while rst=1, every register is 0, every pending bit is 0, the FSM is IDLE and the counter is 0. Asserting rst mid-clear aborts the sequence into IDLE with the full array zeroed.
- **Reset values of outputs:** data_out=0 (unless bypass is active), pending=0, clearing=0.

## Timing
- Read latency 0 cycles (combinational). A written value is visible through bypass in the same cycle and from storage in the following cycle.
- Reserve → pending visible 1 cycle later.
- clear pulse at edge n → clearing=1 from edge n through edge n+DEPTH−1. clearing=0 after edge n+DEPTH. The clear takes exactly DEPTH cycles.
- Counter wraps naturally at DEPTH; it is ADDR_W bits wide.

## Configuration
- REGFILE_ZERO_REG_EN defined:
  - Register 0 always reads 0 and its pending bit always reads 0.
  - Writes and reserves to address 0 are discarded.
  - Bypass never applies to address 0.
- REGFILE_ZERO_REG_EN undefined: register 0 behaves like every other entry.

## Structure
- **Package regfile_pkg:**
  - Default WIDTH, DEPTH and NREAD constants.
  - Clear FSM state typedef: CLR_IDLE, CLR_RUN.
  - Max NREAD constant (4).
- **Sub-module regfile_scoreboard:** holds the DEPTH pending bits, the set/clear priority logic and the per-port pending lookup.
- **Parent regfile_mp:** holds the data array, bypass muxes and clear FSM.

## Test plan
- **Reset:** rst=1 asynchronously mid-cycle → all data_out=0, pending=0 and clearing=0 immediately, without waiting for a clock edge.
- **Write then read:** write 'hACED_CAFE to address 4, address_r port0=4 → port0 shows 'hACED_CAFE in the same cycle (bypass) and still shows it after write drops. A concurrent read of address 1 returns 0.
- **Scoreboard:** reserve address 3, then 2 idle cycles → pending[0]=1 for address 3. Write 'hDEAD_BEEF to address 3 → pending drops the next cycle and data reads 'hDEAD_BEEF.
- **Same-cycle reserve and write to address 5** → address 5 stores the write data, pending=1.
- **Clear:** preload all 16 entries, pulse clear → clearing high exactly 16 cycles. A write to address 7 during the clear is dropped. All entries read 0 afterwards. rst asserted at cycle 8 → clearing=0 at once.
- **REGFILE_ZERO_REG_EN:** write 'h1234 to address 0 and reserve address 0 → address 0 reads 0, pending 0, with no bypass. Without the macro → reads 'h1234 with bypass.
